mips_regfile_2r1w: RTL and testbench

//  32x32 MIPS general-purpose register file: two read ports, one write port.

---
 rtl/mips_pkg.sv | 35 +++
 rtl/regfile_read_port.sv | 66 ++++++
 rtl/mips_regfile_2r1w.sv | 93 +++++++++
 tb/tb_mips_regfile_2r1w.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants and the RegDst select encoding used by mux_5bit.
// Also provides the destination-select helper so producers of waddr agree on its meaning.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        REGDST_RT    = 2'b00,
        REGDST_RD    = 2'b01,
        REGDST_SPARE = 2'b10,
        REGDST_RA    = 2'b11
    } regdst_e;

    // Destination register select; the spare encoding drives index 0 so a stray write is dropped.
    function automatic logic [4:0] regdst_sel(
        input regdst_e    sel,
        input logic [4:0] rt,
        input logic [4:0] rd
    );
        logic [4:0] idx;
        case (sel)
            REGDST_RT:    idx = rt;
            REGDST_RD:    idx = rd;
            REGDST_SPARE: idx = REG_ZERO;
            REGDST_RA:    idx = REG_RA;
            default:      idx = REG_ZERO;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: $0 forcing, same-cycle write bypass, data and valid flops.
// The caller supplies the array word at raddr; this block decides what actually gets returned.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int P_DATA_W = DATA_W,
    parameter int P_ADDR_W = ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                re,
    input  logic [P_ADDR_W-1:0] raddr,
    input  logic                we,
    input  logic [P_ADDR_W-1:0] waddr,
    input  logic [P_DATA_W-1:0] wdata,
    input  logic [P_DATA_W-1:0] stored,
    output logic [P_DATA_W-1:0] rdata,
    output logic                rvalid
);

    logic [P_DATA_W-1:0] value_s;
    logic [P_DATA_W-1:0] rdata_d;
    logic [P_DATA_W-1:0] rdata_q;
    logic                rvalid_d;
    logic                rvalid_q;

    // Resolve the architectural value of raddr for this cycle.
    always_comb begin
        value_s = stored;
        if (raddr == {P_ADDR_W{1'b0}}) begin
            value_s = {P_DATA_W{1'b0}};
        end else if (we && (waddr == raddr)) begin
            value_s = wdata;
        end else begin
            value_s = stored;
        end
    end

    // Capture on request; an idle cycle holds the data but drops valid.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (re) begin
            rdata_d  = value_s;
            rvalid_d = 1'b1;
        end else begin
            rdata_d  = rdata_q;
            rvalid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= {P_DATA_W{1'b0}};
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: rtl/mips_regfile_2r1w.sv
// 32x32 MIPS general-purpose register file, two registered read ports and one write port.
// Storage and write decode live here; each read port handles $0 and write bypass itself.
module mips_regfile_2r1w
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rvalid2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_en_s;

    // Writes to $0 are dropped so that entry never leaves zero.
    always_comb begin
        wr_en_s = 1'b0;
        if (we && (waddr != {ADDR_W{1'b0}})) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next-state of the storage array.
    always_comb begin
        regs_d = regs_q;
        if (wr_en_s) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
    end

    // Storage array, cleared on reset so unwritten registers read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port #(
        .P_DATA_W (DATA_W),
        .P_ADDR_W (ADDR_W)
    ) u_rd1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .re     (re1),
        .raddr  (raddr1),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .stored (regs_q[raddr1]),
        .rdata  (rdata1),
        .rvalid (rvalid1)
    );

    regfile_read_port #(
        .P_DATA_W (DATA_W),
        .P_ADDR_W (ADDR_W)
    ) u_rd2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .re     (re2),
        .raddr  (raddr2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .stored (regs_q[raddr2]),
        .rdata  (rdata2),
        .rvalid (rvalid2)
    );

endmodule

// File: tb/tb_mips_regfile_2r1w.sv
// Directed-vector bench for mips_regfile_2r1w with hand-computed expectations.
module tb_mips_regfile_2r1w;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic        rvalid1;
    logic [31:0] rdata2;
    logic        rvalid2;

    int checks_cnt;
    int errors_cnt;

    mips_regfile_2r1w dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re1     (re1),
        .raddr1  (raddr1),
        .re2     (re2),
        .raddr2  (raddr2),
        .rdata1  (rdata1),
        .rvalid1 (rvalid1),
        .rdata2  (rdata2),
        .rvalid2 (rvalid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        re1 = 1'b0; raddr1 = 5'd0;
        re2 = 1'b0; raddr2 = 5'd0;
    endtask

    // Independent model of the upstream destination mux: rt / rd / spare(0) / $ra.
    function automatic logic [4:0] mux5_model(input logic [1:0] sel, input logic [4:0] a, input logic [4:0] b);
        logic [4:0] r;
        case (sel)
            2'b00:   r = a;
            2'b01:   r = b;
            2'b10:   r = 5'd0;
            2'b11:   r = 5'd31;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        idle();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();

        // Dirty the state so the mid-cycle reset has something to clear.
        we = 1'b1; waddr = 5'd5; wdata = 32'h00000055;
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        tick();
        check_val("pre_reset_rdata1", rdata1, 32'h00000055);
        check_val("pre_reset_rvalid2", {31'd0, rvalid2}, 32'd1);

        // 1: asynchronous reset takes effect immediately, mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_rdata1", rdata1, 32'h0);
        check_val("rst_rdata2", rdata2, 32'h0);
        check_val("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        check_val("rst_rvalid2", {31'd0, rvalid2}, 32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            re1 = 1'b1; raddr1 = i[4:0];
            re2 = 1'b1; raddr2 = 5'(31 - i);
            tick();
            check_val($sformatf("rst_read1_%0d", i), rdata1, 32'h0);
            check_val($sformatf("rst_read2_%0d", 31 - i), rdata2, 32'h0);
        end
        idle();
        tick();
        check_val("idle_rvalid1", {31'd0, rvalid1}, 32'd0);

        // 2: basic write then registered read, plus hold when idle.
        we = 1'b1; waddr = 5'd13; wdata = 32'hDEADBEEF;
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd13;
        tick();
        check_val("wr_rd_rdata1", rdata1, 32'hDEADBEEF);
        check_val("wr_rd_rvalid1", {31'd0, rvalid1}, 32'd1);
        check_val("wr_rd_rvalid2_idle", {31'd0, rvalid2}, 32'd0);
        idle();
        tick();
        check_val("hold_rdata1", rdata1, 32'hDEADBEEF);
        check_val("hold_rvalid1", {31'd0, rvalid1}, 32'd0);

        // 3: $0 write dropped, including the same-cycle bypass path.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        re2 = 1'b1; raddr2 = 5'd0;
        tick();
        check_val("zero_bypass_rdata2", rdata2, 32'h0);
        idle();
        re2 = 1'b1; raddr2 = 5'd0;
        tick();
        check_val("zero_rdata2", rdata2, 32'h0);
        check_val("zero_rvalid2", {31'd0, rvalid2}, 32'd1);

        // 4: write-to-read bypass on both ports at the same index.
        idle();
        we = 1'b1; waddr = 5'd31; wdata = 32'h00400008;
        re1 = 1'b1; raddr1 = 5'd31; re2 = 1'b1; raddr2 = 5'd31;
        tick();
        check_val("bypass_rdata1", rdata1, 32'h00400008);
        check_val("bypass_rdata2", rdata2, 32'h00400008);
        idle();
        re1 = 1'b1; raddr1 = 5'd31; re2 = 1'b1; raddr2 = 5'd13;
        tick();
        check_val("ra_stored_rdata1", rdata1, 32'h00400008);
        check_val("r13_kept_rdata2", rdata2, 32'hDEADBEEF);

        // 5: waddr from the destination mux selecting rd.
        idle();
        we = 1'b1; waddr = mux5_model(2'b01, 5'b10000, 5'b00010); wdata = 32'h12345678;
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd2; re2 = 1'b1; raddr2 = 5'd16;
        tick();
        check_val("mux_reg2", rdata1, 32'h12345678);
        check_val("mux_reg16", rdata2, 32'h0);

        // 6: write pending while reset is held across the edge is discarded.
        idle();
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        #2;
        rst_n = 1'b0;
        tick();
        idle();
        rst_n = 1'b1;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd13;
        tick();
        check_val("rst_wr_reg7", rdata1, 32'h0);
        check_val("rst_wr_reg13", rdata2, 32'h0);
        check_val("rst_wr_rvalid1", {31'd0, rvalid1}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
